serial_sink: RTL

- Bit-serial frame receiver for the perceptron datapath.
- Consumes the single-wire stream produced by the `serial` shifter, which carries a 3-bit lane select and an 8-bit payload per frame.
- Assembles payload bytes into a 64-bit word of eight byte lanes and flags each landed byte and each completed word.
- Sits on the bank side of the serial link; its word output feeds weight/operand storage.

---
 rtl/serial_sink.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_sink.sv
// serial_sink: bit-serial frame receiver for the perceptron datapath.
//
// Receives frames of {start, sel[2:0] LSB first, data[7:0] LSB first,
// [parity], stop} from the serial shifter and writes each payload byte into
// one byte lane of a 64-bit word.
//
// Optional feature macro: SERIAL_SINK_PARITY_EN adds an even-parity bit
// over sel and data ahead of the stop bit; without it parity_err is tied low.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   rx          serial line, idles high
//   clear       zero word/lanes and abort any frame in progress
//   byte_data   last committed payload byte
//   byte_sel    lane of the last committed payload
//   byte_valid  one-cycle pulse per committed byte
//   word        assembled word, lane n at word[8n+7:8n]
//   word_valid  one-cycle pulse when lane 7 is committed
//   lanes       lanes written since the last word_valid or clear
//   frame_err   one-cycle pulse on a bad stop bit
//   parity_err  one-cycle pulse on a parity mismatch
//   busy        high whenever the receiver is not idle
module serial_sink #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        clear,
    output logic [7:0]  byte_data,
    output logic [2:0]  byte_sel,
    output logic        byte_valid,
    output logic [63:0] word,
    output logic        word_valid,
    output logic [7:0]  lanes,
    output logic        frame_err,
    output logic        parity_err,
    output logic        busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEL, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    state_t            state;
    logic [1:0]        sync_q;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [2:0]        sel_sh;
    logic [7:0]        data_sh;
    logic              rx_s;
    logic              bit_tick;
    logic              commit_ok;
    logic [7:0]        lane_hot;

    assign rx_s     = sync_q[1];
    assign bit_tick = (cnt == BIT_LAST);
    assign lane_hot = 8'(1) << sel_sh;

`ifdef SERIAL_SINK_PARITY_EN
    logic par_bad;
    assign commit_ok = ~par_bad;
`else
    assign commit_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Synchronizer, frame FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            sel_sh     <= '0;
            data_sh    <= '0;
            byte_data  <= '0;
            byte_sel   <= '0;
            byte_valid <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            lanes      <= '0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef SERIAL_SINK_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], rx};
            byte_valid <= 1'b0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SERIAL_SINK_PARITY_EN
            parity_err <= 1'b0;
`endif
            // lanes drops to zero the cycle after a completed word
            if (word_valid) begin
                lanes <= '0;
            end

            if (clear) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
                idx   <= '0;
                word  <= '0;
                lanes <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state <= S_START;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                    // half-bit wait so later samples land mid-bit
                    S_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt <= '0;
                            idx <= '0;
                            if (rx_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_SEL;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_SEL: begin
                        cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
                        if (bit_tick) begin
                            sel_sh <= {rx_s, sel_sh[2:1]};
                            if (idx == 3'd2) begin
                                idx   <= '0;
                                state <= S_DATA;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
                        if (bit_tick) begin
                            data_sh <= {rx_s, data_sh[7:1]};
                            idx     <= idx + 3'd1;
                            if (idx == 3'd7) begin
`ifdef SERIAL_SINK_PARITY_EN
                                state <= S_PAR;
`else
                                state <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef SERIAL_SINK_PARITY_EN
                    S_PAR: begin
                        cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
                        if (bit_tick) begin
                            par_bad <= rx_s ^ (^sel_sh) ^ (^data_sh);
                            state   <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
                        if (bit_tick) begin
`ifdef SERIAL_SINK_PARITY_EN
                            parity_err <= par_bad;
`endif
                            if (rx_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                if (commit_ok) begin
                                    byte_data                  <= data_sh;
                                    byte_sel                   <= sel_sh;
                                    byte_valid                 <= 1'b1;
                                    word[{sel_sh, 3'b000} +: 8] <= data_sh;
                                    lanes <= (word_valid ? 8'h00 : lanes) | lane_hot;
                                    word_valid                 <= (sel_sh == 3'd7);
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end
                    end
                    // line held low after a bad stop: wait for it to idle
                    S_BREAK: begin
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
